// File: rtl/store_unit_if.sv
// -----------------------------------------------------------------------------
// store_unit_if
// Memory-mapped IO write channel driven by the store unit.
//   io_valid  : write request pending (master -> slave)
//   io_ready  : sink accepts; transfer happens when io_valid && io_ready
//   io_addr   : IO byte address
//   io_data   : lane-shifted write data
//   io_be     : per-byte enables
// Modports: master (store unit side), slave (IO sink side).
// -----------------------------------------------------------------------------
interface store_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  io_valid;
  logic                  io_ready;
  logic [ADDR_W-1:0]     io_addr;
  logic [DATA_W-1:0]     io_data;
  logic [DATA_W/8-1:0]   io_be;

  modport master (output io_valid, io_addr, io_data, io_be, input io_ready);
  modport slave  (input io_valid, io_addr, io_data, io_be, output io_ready);
endinterface

// File: rtl/store_unit.sv
// -----------------------------------------------------------------------------
// store_unit
// Write-side counterpart of the load path. Turns an EXE-stage store request
// into byte-lane-aligned write data and per-lane enables for DMEM/IMEM, and
// issues memory-mapped IO writes over a valid/ready channel while stalling
// the pipeline. All outputs are registered (one cycle of latency).
//
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   st_valid        store request present
//   st_type         00=SB 01=SH 10=SW 11=reserved (no store)
//   st_addr/st_data byte address and unaligned rs2 value
//   dmem_we/imem_we per-byte write enables
//   mem_addr        word address st_addr[31:2]
//   mem_din         lane-shifted store data
//   io              IO write channel (store_unit_if.master)
//   stall           high while an IO write is pending
//   misalign        one-cycle pulse on a misaligned store
//   misalign_cnt    saturating misaligned-store count (only with the macro)
//
// Region decode on st_addr[31:28]: 0001 DMEM, 0010 IMEM, 0011 both, 1000 IO.
//
// Optional feature macro: STORE_MISALIGN_FIX_EN
//   defined   : misaligned stores are forced to alignment and still written;
//               misalign still pulses; misalign_cnt port is added.
//   undefined : misaligned stores are dropped.
// -----------------------------------------------------------------------------
module store_unit #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int IO_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              st_valid,
  input  logic [1:0]        st_type,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [DATA_W-1:0] st_data,
  output logic [3:0]        dmem_we,
  output logic [3:0]        imem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  store_unit_if.master      io,
  output logic              stall,
  output logic              misalign
`ifdef STORE_MISALIGN_FIX_EN
  ,
  output logic [15:0]       misalign_cnt
`endif
);

  localparam int         CNT_W = $clog2(IO_TIMEOUT + 1);
  localparam logic [1:0] ST_SB = 2'b00;
  localparam logic [1:0] ST_SH = 2'b01;
  localparam logic [1:0] ST_SW = 2'b10;

  typedef enum logic {IDLE, IO_REQ} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [3:0]        dmem_we_q, dmem_we_d;
  logic [3:0]        imem_we_q, imem_we_d;
  logic [ADDR_W-3:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_din_q, mem_din_d;
  logic [ADDR_W-1:0] io_addr_q, io_addr_d;
  logic [DATA_W-1:0] io_data_q, io_data_d;
  logic [3:0]        io_be_q, io_be_d;
  logic              misalign_q, misalign_d;

  logic              accept;
  logic              mis_c;
  logic              write_ok;
  logic              io_start;
  logic [1:0]        addr_lo;
  logic [3:0]        region;
  logic [3:0]        lane_be;
  logic [3:0]        wr_be;
  logic [DATA_W-1:0] lane_data;

  assign region = st_addr[ADDR_W-1 -: 4];
  // Requests arriving while an IO write is pending are ignored: upstream is stalled.
  assign accept = st_valid && (state_q == IDLE) && (st_type != 2'b11);
  assign mis_c  = ((st_type == ST_SH) && st_addr[0]) ||
                  ((st_type == ST_SW) && (st_addr[1:0] != 2'b00));

`ifdef STORE_MISALIGN_FIX_EN
  // Force the low address bits to the access size and let the write proceed.
  assign addr_lo  = (st_type == ST_SW) ? 2'b00 :
                    (st_type == ST_SH) ? {st_addr[1], 1'b0} : st_addr[1:0];
  assign write_ok = 1'b1;
`else
  assign addr_lo  = st_addr[1:0];
  assign write_ok = !mis_c;
`endif

  // Lane formation: replicate the narrow value across the word so the lane
  // selected by the enables always carries the right bytes.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    lane_be   = 4'b0000;
    lane_data = st_data;
    case (st_type)
      ST_SB: begin
        lane_be   = 4'b0001 << addr_lo;
        lane_data = {4{st_data[7:0]}};
      end
      ST_SH: begin
        lane_be   = addr_lo[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{st_data[15:0]}};
      end
      ST_SW:   lane_be = 4'b1111;
      default: lane_be = 4'b0000;
    endcase
  end

  assign wr_be    = (accept && write_ok) ? lane_be : 4'b0000;
  assign io_start = accept && write_ok && (region == 4'b1000);

  // Memory write path: enables live for exactly the cycle after the request.
  always_comb begin
    dmem_we_d  = ((region == 4'b0001) || (region == 4'b0011)) ? wr_be : 4'b0000;
    imem_we_d  = ((region == 4'b0010) || (region == 4'b0011)) ? wr_be : 4'b0000;
    misalign_d = accept && mis_c;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    if (accept) begin
      mem_addr_d = st_addr[ADDR_W-1:2];
      mem_din_d  = lane_data;
    end
  end

  // IO FSM: capture the request, then hold it stable until accepted or timed out.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    io_addr_d = io_addr_q;
    io_data_d = io_data_q;
    io_be_d   = io_be_q;
    case (state_q)
      IDLE: begin
        if (io_start) begin
          state_d   = IO_REQ;
          cnt_d     = '0;
          io_addr_d = {st_addr[ADDR_W-1:2], addr_lo};
          io_data_d = lane_data;
          io_be_d   = lane_be;
        end
      end
      IO_REQ: begin
        // The counter tracks completed wait cycles; the request is abandoned
        // after IO_TIMEOUT cycles of io_valid without io_ready.
        if (io.io_ready || (cnt_q == CNT_W'(IO_TIMEOUT - 1))) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      dmem_we_q  <= '0;
      imem_we_q  <= '0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      io_addr_q  <= '0;
      io_data_q  <= '0;
      io_be_q    <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dmem_we_q  <= dmem_we_d;
      imem_we_q  <= imem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      io_addr_q  <= io_addr_d;
      io_data_q  <= io_data_d;
      io_be_q    <= io_be_d;
      misalign_q <= misalign_d;
    end
  end

`ifdef STORE_MISALIGN_FIX_EN
  logic [15:0] mcnt_q, mcnt_d;

  assign mcnt_d = (misalign_d && (mcnt_q != 16'hFFFF)) ? mcnt_q + 16'd1 : mcnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) mcnt_q <= '0;
    else     mcnt_q <= mcnt_d;
  end

  assign misalign_cnt = mcnt_q;
`endif

  // io_valid and stall decode the state flop directly, so reset clears them
  // without waiting for an edge.
  assign io.io_valid = (state_q == IO_REQ);
  assign io.io_addr  = io_addr_q;
  assign io.io_data  = io_data_q;
  assign io.io_be    = io_be_q;
  assign stall       = (state_q == IO_REQ);
  assign dmem_we     = dmem_we_q;
  assign imem_we     = imem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_din     = mem_din_q;
  assign misalign    = misalign_q;

endmodule

// File: doc/store_unit.md
Name: store_unit

Overview:
- Write-side counterpart of the load path. Takes store requests from the EXE stage and produces byte-lane-aligned write data and per-lane write enables for DMEM and IMEM.
- Also drives a memory-mapped IO write channel with a valid/ready handshake, holding the pipeline stalled until the IO write is accepted.
- Sits between the EXE stage and the memory/IO write ports. Outputs are registered, giving one cycle of latency.

Parameters:
- ADDR_W, 32, address width; upper 4 bits used for region decode
- DATA_W, 32, data width; fixed at 32, 4 byte lanes
- IO_TIMEOUT, 255, cycles to wait for io_ready before abandoning an IO write

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- st_valid  in  1  store request present this cycle
- st_type  in  2  00=SB, 01=SH, 10=SW, 11=reserved (treated as no store)
- st_addr  in  32  byte address from ALU
- st_data  in  32  rs2 value, unaligned
- dmem_we  out  4  DMEM per-byte write enable
- imem_we  out  4  IMEM per-byte write enable
- mem_addr  out  30  word address, st_addr[31:2]
- mem_din  out  32  lane-shifted store data
- io_valid  out  1  IO write request
- io_ready  in  1  IO sink accepts when io_valid && io_ready
- io_addr  out  32  IO byte address
- io_data  out  32  IO write data, lane-shifted
- io_be  out  4  IO byte enables
- stall  out  1  freezes upstream stages while an IO write is pending
- misalign  out  1  one-cycle pulse on a dropped misaligned store

Behaviour:
- Reset (async, rst=1): all outputs 0; FSM in IDLE; timeout counter 0.
- Lane formation:
  - SB: be = 1 << addr[1:0]; data = {4{st_data[7:0]}}.
  - SH: be = 0011 or 1100 by addr[1]; data = {2{st_data[15:0]}}.
  - SW: be = 1111; data = st_data.
- Misalignment: SH with addr[0]=1, or SW with addr[1:0]!=0.
  - The store is dropped: no enables asserted.
  - misalign pulses high for 1 cycle, aligned with where the enables would have appeared.
- Region decode on st_addr[31:28]:
  - 0001: DMEM only.
  - 0010: IMEM only.
  - 0011: DMEM and IMEM (both enable sets).
  - 1000: IO.
  - Anything else: no write, no error.
- Latency: an accepted memory store has its enables, mem_addr and mem_din registered and valid for exactly 1 cycle, the cycle after st_valid. Enables return to 0 the following cycle unless a new store arrives. Back-to-back stores are supported every cycle.
- IO FSM:
  - IDLE: st_valid with an aligned IO-region store → IO_REQ on the next edge. Latch io_addr/io_data/io_be, assert io_valid, clear the counter.
  - IO_REQ: stall=1 combinationally from the cycle the request is captured through the accept cycle. io_valid, io_addr, io_data and io_be stay stable until handshake.
    - io_ready=1 → IDLE; io_valid drops on the next edge.
    - Counter reaches IO_TIMEOUT without io_ready → IDLE; io_valid drops; request abandoned.
- st_valid while in IO_REQ is ignored; upstream is stalled, so none is expected.
- io_ready high while io_valid=0 has no effect.
- st_type=11 or st_valid=0: no write, FSM unchanged.
- rst asserted mid IO_REQ: immediate return to IDLE, io_valid and stall low asynchronously.

Optional Feature:
- Macro: STORE_MISALIGN_FIX_EN
- Defined:
  - Misaligned stores are not dropped; address low bits are forced to alignment (SH clears addr[0], SW clears addr[1:0]) and the write proceeds.
  - misalign still pulses.
  - A 16-bit saturating counter misalign_cnt is exposed as an extra output port; it resets to 0, increments per misaligned store and holds at 0xFFFF.
- Not defined: drop behaviour as above; no misalign_cnt port.

Test Plan:
- SB, addr=0x1000_0003, data=0x0000_00A5 → next cycle: dmem_we=1000, mem_din=0xA5A5_A5A5, mem_addr=0x0400_0000, imem_we=0000.
- SH, addr=0x3000_0006, data=0x1234_BEEF → dmem_we=imem_we=1100, mem_din=0xBEEF_BEEF. Then SW 0x1000_0001 the next cycle → no enables, misalign=1 (with STORE_MISALIGN_FIX_EN: dmem_we=1111 at word 0x0400_0000, misalign_cnt=1).
- SW, addr=0x8000_0008, data=0xDEAD_BEEF, io_ready held 0 for 5 cycles then 1 → io_valid high 6 cycles with data stable, stall high through the accept cycle, then IDLE.
- IO store with io_ready never asserted, IO_TIMEOUT=4 → io_valid drops after 4 wait cycles, stall releases, no further request.
- rst pulsed during IO_REQ → io_valid, stall and all enables go 0 immediately, without waiting for a clock edge. Next IO store after reset completes normally.
- Three back-to-back SW to 0x1000_0000/4/8 → three consecutive cycles of dmem_we=1111 with matching mem_addr, stall never asserted.
